// File: rtl/stage_controller.sv
// Round sequencer for a PU array: steps LOAD -> GROW -> MERGE (repeat) -> PEELING -> RESULT,
// using a per-state pipe-delay blanking window and an all-idle settle count to end MERGE/PEELING.
//
// state          | meaning
// S_IDLE         | waiting for start; round results held
// S_LOAD         | measurement loading, one cycle
// S_GROW         | grow broadcast, one cycle, counted
// S_MERGE        | wait for PUs to settle, then grow again or peel
// S_PEEL         | wait for PUs to settle, then report
// S_RESULT       | one-cycle result_valid pulse
module stage_controller #(
  parameter int PU_COUNT    = 16,
  parameter int STAGE_WIDTH = 3,
  parameter int MAX_GROW    = 15,
  parameter int PIPE_DELAY  = 3,
  parameter int SETTLE      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PU_COUNT-1:0]    busy,
  input  logic [PU_COUNT-1:0]    odd,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   result_valid,
  output logic [3:0]             grow_count,
  output logic [15:0]            cycle_count,
  output logic                   grow_overflow
);

  localparam int WAIT_W = $clog2(PIPE_DELAY + 2);
  localparam int SET_W  = $clog2(SETTLE + 2);

  typedef enum logic [STAGE_WIDTH-1:0] {
    S_IDLE   = STAGE_WIDTH'(0),
    S_LOAD   = STAGE_WIDTH'(1),
    S_GROW   = STAGE_WIDTH'(2),
    S_MERGE  = STAGE_WIDTH'(3),
    S_PEEL   = STAGE_WIDTH'(4),
    S_RESULT = STAGE_WIDTH'(5)
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [3:0]        grow_q, grow_d;
  logic [15:0]       cyc_q, cyc_d;
  logic              ovf_q, ovf_d;
  logic              rv_q;
  logic              settled;
  logic              any_odd;

  assign any_odd = |odd;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    grow_d   = grow_q;
    cyc_d    = cyc_q;
    ovf_d    = ovf_q;
    settled  = 1'b0;

    if (state_q != S_IDLE && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;

    // busy is blanked while in-flight PU work from the previous stage drains
    if (state_q == S_MERGE || state_q == S_PEEL) begin
      if (wait_q < WAIT_W'(PIPE_DELAY)) begin
        wait_d = wait_q + WAIT_W'(1);
      end else if (|busy) begin
        settle_d = '0;
      end else begin
        settle_d = settle_q + SET_W'(1);
        settled  = (settle_d == SET_W'(SETTLE));
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          grow_d  = '0;
          cyc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_GROW;
        grow_d  = grow_q + 4'd1;
      end
      S_GROW: state_d = S_MERGE;
      S_MERGE: begin
        if (settled) begin
          if (any_odd && grow_q < 4'(MAX_GROW)) begin
            state_d = S_GROW;
            grow_d  = grow_q + 4'd1;
          end else begin
            state_d = S_PEEL;
            if (any_odd && grow_q == 4'(MAX_GROW)) ovf_d = 1'b1;
          end
        end
      end
      S_PEEL:   if (settled) state_d = S_RESULT;
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      wait_d   = '0;
      settle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      settle_q <= '0;
      grow_q   <= '0;
      cyc_q    <= '0;
      ovf_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      settle_q <= settle_d;
      grow_q   <= grow_d;
      cyc_q    <= cyc_d;
      ovf_q    <= ovf_d;
      rv_q     <= (state_d == S_RESULT);
    end
  end

  assign global_stage  = state_q;
  assign result_valid  = rv_q;
  assign grow_count    = grow_q;
  assign cycle_count   = cyc_q;
  assign grow_overflow = ovf_q;

endmodule

// File: tb/tb_stage_controller.sv
// Randomized bench for stage_controller: each round is planned up front as an expected
// stage-per-cycle list derived from the settle/grow rules, then replayed against the DUT.
module tb_stage_controller;
  localparam int PU = 16;
  localparam int PD = 3;
  localparam int ST = 2;
  localparam int MG = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PU-1:0] busy;
  logic [PU-1:0] odd;
  logic [2:0]    global_stage;
  logic          result_valid;
  logic [3:0]    grow_count;
  logic [15:0]   cycle_count;
  logic          grow_overflow;

  stage_controller #(
    .PU_COUNT(PU), .STAGE_WIDTH(3), .MAX_GROW(MG), .PIPE_DELAY(PD), .SETTLE(ST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .odd(odd),
    .global_stage(global_stage), .result_valid(result_valid), .grow_count(grow_count),
    .cycle_count(cycle_count), .grow_overflow(grow_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int            q_stage[$];
  logic [PU-1:0] q_busy[$];
  logic [PU-1:0] q_odd[$];
  bit            q_start[$];
  int            e_grow, e_ovf, e_cc;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int stg, input logic [PU-1:0] b, input logic [PU-1:0] o, input bit s);
    q_stage.push_back(stg);
    q_busy.push_back(b);
    q_odd.push_back(o);
    q_start.push_back(s);
  endtask

  function automatic logic [PU-1:0] rand_vec();
    return PU'($urandom_range(0, 16'hFFFF));
  endfunction

  // oddv: 1 = odd set on exit cycle, 0 = clear on exit, -1 = don't care throughout
  task automatic add_phase(input int stg, input int bmode, input int oddv);
    logic [PU-1:0] pat[$];
    logic [PU-1:0] b;
    logic [PU-1:0] o;
    int            d;
    bit            clean;
    for (int k = 0; k < 60; k++) begin
      b = '0;
      case (bmode)
        1: if (k < 30 && $urandom_range(0, 2) == 0) b = PU'(1) << $urandom_range(0, PU - 1);
        2: if (k == 1 || (k >= 3 && k <= 5)) b[5] = 1'b1;
        default: ;
      endcase
      pat.push_back(b);
    end
    // exit at the end of the first ST-long all-idle window lying fully past the blanking
    d = 0;
    for (int k = PD + ST - 1; k < 60 && d == 0; k++) begin
      clean = 1'b1;
      for (int j = k - ST + 1; j <= k; j++) if (pat[j] != '0) clean = 1'b0;
      if (clean) d = k + 1;
    end
    for (int k = 0; k < d; k++) begin
      o = rand_vec();
      if (k == d - 1 && oddv == 1) o = PU'($urandom_range(1, 16'hFFFF));
      if (k == d - 1 && oddv == 0) o = '0;
      push(stg, pat[k], o, $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic build_round(input int bmode, input int omode);
    int exits;
    int o;
    q_stage.delete(); q_busy.delete(); q_odd.delete(); q_start.delete();
    exits  = 0;
    e_grow = 0;
    e_ovf  = 0;
    push(0, rand_vec(), rand_vec(), 1'b1);
    push(1, rand_vec(), rand_vec(), $urandom_range(0, 1) == 1);
    forever begin
      push(2, rand_vec(), rand_vec(), $urandom_range(0, 1) == 1);
      e_grow++;
      case (omode)
        0:       o = 0;
        1:       o = 1;
        2:       o = (exits < 2) ? 1 : 0;
        default: o = ($urandom_range(0, 2) == 0) ? 1 : 0;
      endcase
      exits++;
      add_phase(3, bmode, o);
      if (o == 1 && e_grow < MG) continue;
      if (o == 1) e_ovf = 1;
      break;
    end
    add_phase(4, bmode, -1);
    push(5, rand_vec(), rand_vec(), 1'b1);
    e_cc = q_stage.size() - 1;
    push(0, rand_vec(), rand_vec(), 1'b0);
  endtask

  task automatic run_entries(input int n);
    int lim;
    lim = (n < 0 || n > q_stage.size()) ? q_stage.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      chk("stage", int'(global_stage), q_stage[i]);
      chk("result_valid", int'(result_valid), (q_stage[i] == 5) ? 1 : 0);
      busy  = q_busy[i];
      odd   = q_odd[i];
      start = q_start[i];
    end
  endtask

  task automatic run_round(input string name, input int bmode, input int omode);
    build_round(bmode, omode);
    run_entries(-1);
    @(negedge clk);
    start = 1'b0;
    chk({name, " idle"}, int'(global_stage), 0);
    chk({name, " grow_count"}, int'(grow_count), e_grow);
    chk({name, " cycle_count"}, int'(cycle_count), e_cc);
    chk({name, " grow_overflow"}, int'(grow_overflow), e_ovf);
  endtask

  initial begin
    int peel_at;
    reset = 1'b0;
    start = 1'b0;
    busy  = '0;
    odd   = '0;
    #1;
    chk("reset stage", int'(global_stage), 0);
    chk("reset rv", int'(result_valid), 0);
    chk("reset grow", int'(grow_count), 0);
    chk("reset cycles", int'(cycle_count), 0);
    chk("reset ovf", int'(grow_overflow), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_round("basic", 0, 0);
    chk("basic grow=1", int'(grow_count), 1);
    chk("basic cycles=13", int'(cycle_count), 13);
    run_round("two_regrow", 0, 2);
    chk("two_regrow grow=3", int'(grow_count), 3);
    run_round("overflow", 0, 1);
    chk("overflow grow=15", int'(grow_count), 15);
    chk("overflow flag", int'(grow_overflow), 1);
    run_round("busy_window", 2, 0);
    for (int r = 0; r < 10; r++) run_round("random", 1, 3);

    // asynchronous reset in the middle of PEELING
    build_round(1, 3);
    peel_at = 0;
    foreach (q_stage[i]) if (q_stage[i] == 4 && peel_at == 0) peel_at = i;
    run_entries(peel_at + 2);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset stage", int'(global_stage), 0);
    chk("midreset rv", int'(result_valid), 0);
    chk("midreset grow", int'(grow_count), 0);
    chk("midreset cycles", int'(cycle_count), 0);
    chk("midreset ovf", int'(grow_overflow), 0);
    @(negedge clk);
    chk("held reset stage", int'(global_stage), 0);
    busy  = '0;
    odd   = '0;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start after reset", int'(global_stage), 1);
    @(negedge clk);
    chk("grow after reset", int'(global_stage), 2);
    chk("grow_count after reset", int'(grow_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
